shift_operand_stage: RTL and testbench

- ID/EX pipeline stage that registers decoded shift operands and feeds the 16-bit barrel shifter in the execute stage.
- Selects shift data and count from the register file, the immediate field, or the EX/MEM and MEM/WB forwarding buses.
- Detects load-use hazards against the instruction it currently holds.
- Supports downstream stall and branch flush.

---
 rtl/shift_operand_stage.sv | 129 ++++++++++++
 tb/tb_shift_operand_stage.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/shift_operand_stage.sv
// ID/EX stage holding decoded shift operands for the execute-stage barrel shifter.
// Define SHIFT_FWD_EN for operand forwarding; otherwise a full register interlock is used.
module shift_operand_stage #(
  parameter int DW = 16,
  parameter int CW = 4,
  parameter int RW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          dec_valid,
  input  logic          dec_is_shift,
  input  logic          dec_is_load,
  input  logic          dec_rd_wr,
  input  logic [RW-1:0] dec_rs_idx,
  input  logic [RW-1:0] dec_rt_idx,
  input  logic [DW-1:0] dec_rs_val,
  input  logic [DW-1:0] dec_rt_val,
  input  logic          dec_use_imm,
  input  logic [CW-1:0] dec_imm_cnt,
  input  logic [1:0]    dec_op,
  input  logic [RW-1:0] dec_rd_idx,
  input  logic          stall_in,
  input  logic          flush,
  input  logic          exmem_wr_en,
  input  logic [RW-1:0] exmem_rd_idx,
  input  logic [DW-1:0] exmem_data,
  input  logic          memwb_wr_en,
  input  logic [RW-1:0] memwb_rd_idx,
  input  logic [DW-1:0] memwb_data,
  output logic          sh_valid,
  output logic [DW-1:0] sh_in,
  output logic [CW-1:0] sh_cnt,
  output logic [1:0]    sh_op,
  output logic [RW-1:0] ex_rd_idx,
  output logic          hazard_stall
);

  logic          vld_p1, is_shift_p1, is_load_p1, rd_wr_p1, use_imm_p1;
  logic [RW-1:0] rs_idx_p1, rt_idx_p1, rd_idx_p1;
  logic [DW-1:0] rs_val_p1, rt_val_p1;
  logic [CW-1:0] imm_cnt_p1;
  logic [1:0]    op_p1;
  logic [DW-1:0] rs_fwd, rt_fwd;
  logic          load_use, interlock;
  logic          unused_bits;

  // True when a writer of register idx feeds either source of the decoding instruction.
  function automatic logic src_hit(input logic wr, input logic [RW-1:0] idx,
                                   input logic [RW-1:0] rs, input logic [RW-1:0] rt,
                                   input logic use_imm);
    return wr && ((idx == rs) || (!use_imm && (idx == rt)));
  endfunction

  assign load_use = dec_valid && vld_p1 && is_load_p1 &&
                    src_hit(rd_wr_p1, rd_idx_p1, dec_rs_idx, dec_rt_idx, dec_use_imm);

`ifdef SHIFT_FWD_EN
  // EX/MEM is the younger result, so it wins over MEM/WB.
  function automatic logic [DW-1:0] fwd_pick(input logic [RW-1:0] idx, input logic [DW-1:0] rf_val,
                                             input logic ex_wr, input logic [RW-1:0] ex_idx,
                                             input logic [DW-1:0] ex_data,
                                             input logic mem_wr, input logic [RW-1:0] mem_idx,
                                             input logic [DW-1:0] mem_data);
    if (ex_wr && (ex_idx == idx)) return ex_data;
    if (mem_wr && (mem_idx == idx)) return mem_data;
    return rf_val;
  endfunction

  assign rs_fwd = fwd_pick(rs_idx_p1, rs_val_p1, exmem_wr_en, exmem_rd_idx, exmem_data,
                           memwb_wr_en, memwb_rd_idx, memwb_data);
  assign rt_fwd = fwd_pick(rt_idx_p1, rt_val_p1, exmem_wr_en, exmem_rd_idx, exmem_data,
                           memwb_wr_en, memwb_rd_idx, memwb_data);
  assign interlock = 1'b0;
`else
  assign rs_fwd = rs_val_p1;
  assign rt_fwd = rt_val_p1;
  assign interlock = dec_valid && (
    src_hit(exmem_wr_en, exmem_rd_idx, dec_rs_idx, dec_rt_idx, dec_use_imm) ||
    src_hit(memwb_wr_en, memwb_rd_idx, dec_rs_idx, dec_rt_idx, dec_use_imm) ||
    src_hit(vld_p1 && rd_wr_p1, rd_idx_p1, dec_rs_idx, dec_rt_idx, dec_use_imm));
`endif

  assign hazard_stall = (load_use || interlock) && !stall_in && !flush;

  // Stage boundary: decode -> p1 (ID/EX register)
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1      <= 1'b0;
      is_shift_p1 <= 1'b0;
      is_load_p1  <= 1'b0;
      rd_wr_p1    <= 1'b0;
      use_imm_p1  <= 1'b0;
      rs_idx_p1   <= '0;
      rt_idx_p1   <= '0;
      rd_idx_p1   <= '0;
      rs_val_p1   <= '0;
      rt_val_p1   <= '0;
      imm_cnt_p1  <= '0;
      op_p1       <= '0;
    end else if (flush || (!stall_in && hazard_stall)) begin
      vld_p1     <= 1'b0;
      is_load_p1 <= 1'b0;
      rd_wr_p1   <= 1'b0;
    end else if (!stall_in) begin
      vld_p1      <= dec_valid;
      is_shift_p1 <= dec_is_shift;
      is_load_p1  <= dec_is_load;
      rd_wr_p1    <= dec_rd_wr;
      use_imm_p1  <= dec_use_imm;
      rs_idx_p1   <= dec_rs_idx;
      rt_idx_p1   <= dec_rt_idx;
      rd_idx_p1   <= dec_rd_idx;
      rs_val_p1   <= dec_rs_val;
      rt_val_p1   <= dec_rt_val;
      imm_cnt_p1  <= dec_imm_cnt;
      op_p1       <= dec_op;
    end
  end

  // Register counts wrap to the low CW bits; no saturation.
  assign sh_valid  = vld_p1 && is_shift_p1;
  assign sh_in     = rs_fwd;
  assign sh_cnt    = use_imm_p1 ? imm_cnt_p1 : rt_fwd[CW-1:0];
  assign sh_op     = op_p1;
  assign ex_rd_idx = rd_idx_p1;

  assign unused_bits = ^{rt_fwd[DW-1:CW], rs_idx_p1, rt_idx_p1, exmem_data, memwb_data};

endmodule

// File: tb/tb_shift_operand_stage.sv
// Scoreboard bench for shift_operand_stage; covers both SHIFT_FWD_EN builds.
module tb_shift_operand_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic        dec_valid, dec_is_shift, dec_is_load, dec_rd_wr, dec_use_imm;
  logic [2:0]  dec_rs_idx, dec_rt_idx, dec_rd_idx;
  logic [15:0] dec_rs_val, dec_rt_val;
  logic [3:0]  dec_imm_cnt;
  logic [1:0]  dec_op;
  logic        stall_in, flush;
  logic        exmem_wr_en, memwb_wr_en;
  logic [2:0]  exmem_rd_idx, memwb_rd_idx;
  logic [15:0] exmem_data, memwb_data;
  logic        sh_valid, hazard_stall;
  logic [15:0] sh_in;
  logic [3:0]  sh_cnt;
  logic [1:0]  sh_op;
  logic [2:0]  ex_rd_idx;

  typedef struct {
    logic [15:0] din;
    logic [3:0]  cnt;
    logic [1:0]  op;
    logic [2:0]  rd;
  } exp_t;
  exp_t sbq[$];

  int n_checks = 0;
  int n_errors = 0;

  shift_operand_stage dut (
    .clk(clk), .rst(rst),
    .dec_valid(dec_valid), .dec_is_shift(dec_is_shift), .dec_is_load(dec_is_load),
    .dec_rd_wr(dec_rd_wr), .dec_rs_idx(dec_rs_idx), .dec_rt_idx(dec_rt_idx),
    .dec_rs_val(dec_rs_val), .dec_rt_val(dec_rt_val), .dec_use_imm(dec_use_imm),
    .dec_imm_cnt(dec_imm_cnt), .dec_op(dec_op), .dec_rd_idx(dec_rd_idx),
    .stall_in(stall_in), .flush(flush),
    .exmem_wr_en(exmem_wr_en), .exmem_rd_idx(exmem_rd_idx), .exmem_data(exmem_data),
    .memwb_wr_en(memwb_wr_en), .memwb_rd_idx(memwb_rd_idx), .memwb_data(memwb_data),
    .sh_valid(sh_valid), .sh_in(sh_in), .sh_cnt(sh_cnt), .sh_op(sh_op),
    .ex_rd_idx(ex_rd_idx), .hazard_stall(hazard_stall)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic sh, input logic ld, input logic wr,
                       input logic [2:0] rs, input logic [2:0] rt, input logic [2:0] rd,
                       input logic [15:0] rsv, input logic [15:0] rtv,
                       input logic ui, input logic [3:0] imm, input logic [1:0] op);
    dec_valid = 1'b1; dec_is_shift = sh; dec_is_load = ld; dec_rd_wr = wr;
    dec_rs_idx = rs; dec_rt_idx = rt; dec_rd_idx = rd;
    dec_rs_val = rsv; dec_rt_val = rtv;
    dec_use_imm = ui; dec_imm_cnt = imm; dec_op = op;
  endtask

  task automatic push(input logic [15:0] din, input logic [3:0] cnt,
                      input logic [1:0] op, input logic [2:0] rd);
    exp_t e;
    e.din = din; e.cnt = cnt; e.op = op; e.rd = rd;
    sbq.push_back(e);
  endtask

  // Called after the edge where a valid shift was captured.
  task automatic pop_cmp(input string tag);
    exp_t e;
    if (sbq.size() == 0) begin
      check({tag, "_underflow"}, 32'(sbq.size()), 32'd1);
    end else begin
      e = sbq.pop_front();
      check({tag, "_vld"}, 32'(sh_valid), 32'd1);
      check({tag, "_in"},  32'(sh_in),    32'(e.din));
      check({tag, "_cnt"}, 32'(sh_cnt),   32'(e.cnt));
      check({tag, "_op"},  32'(sh_op),    32'(e.op));
      check({tag, "_rd"},  32'(ex_rd_idx), 32'(e.rd));
    end
  endtask

  task automatic idle_tick();
    dec_valid = 1'b0; dec_is_load = 1'b0; dec_rd_wr = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b1; stall_in = 1'b0; flush = 1'b0;
    dec_valid = 1'b0; dec_is_shift = 1'b0; dec_is_load = 1'b0; dec_rd_wr = 1'b0;
    dec_rs_idx = '0; dec_rt_idx = '0; dec_rd_idx = '0; dec_rs_val = '0; dec_rt_val = '0;
    dec_use_imm = 1'b0; dec_imm_cnt = '0; dec_op = '0;
    exmem_wr_en = 1'b0; exmem_rd_idx = '0; exmem_data = '0;
    memwb_wr_en = 1'b0; memwb_rd_idx = '0; memwb_data = '0;
    tick(); tick();
    check("rst_vld", 32'(sh_valid), 32'd0);
    check("rst_in",  32'(sh_in),    32'd0);
    check("rst_cnt", 32'(sh_cnt),   32'd0);
    check("rst_op",  32'(sh_op),    32'd0);
    check("rst_rd",  32'(ex_rd_idx), 32'd0);
    check("rst_haz", 32'(hazard_stall), 32'd0);
    rst = 1'b0;

    // SLL by immediate 4
    drive(1'b1, 1'b0, 1'b1, 3'd1, 3'd0, 3'd6, 16'h00F1, 16'h0000, 1'b1, 4'd4, 2'b00);
    push(16'h00F1, 4'd4, 2'b00, 3'd6);
    tick();
    pop_cmp("imm");
    idle_tick();
    check("idle_vld", 32'(sh_valid), 32'd0);

`ifdef SHIFT_FWD_EN
    // Forwarding priority on the data operand
    drive(1'b1, 1'b0, 1'b0, 3'd2, 3'd0, 3'd7, 16'h1111, 16'h0000, 1'b1, 4'd1, 2'b11);
    exmem_wr_en = 1'b1; exmem_rd_idx = 3'd2; exmem_data = 16'hAAAA;
    memwb_wr_en = 1'b1; memwb_rd_idx = 3'd2; memwb_data = 16'h5555;
    push(16'hAAAA, 4'd1, 2'b11, 3'd7);
    tick();
    pop_cmp("fwd_ex");
    exmem_wr_en = 1'b0;
    #1;
    check("fwd_mem_in", 32'(sh_in), 32'h5555);
    memwb_wr_en = 1'b0;
    #1;
    check("fwd_rf_in", 32'(sh_in), 32'h1111);
    idle_tick();
`else
    // Full interlock against an in-flight EX/MEM writer
    drive(1'b1, 1'b0, 1'b0, 3'd5, 3'd0, 3'd1, 16'h0F0F, 16'h0000, 1'b1, 4'd2, 2'b01);
    exmem_wr_en = 1'b1; exmem_rd_idx = 3'd5; exmem_data = 16'hDEAD;
    #1;
    check("ilk_haz0", 32'(hazard_stall), 32'd1);
    tick();
    check("ilk_bub0", 32'(sh_valid), 32'd0);
    check("ilk_haz1", 32'(hazard_stall), 32'd1);
    tick();
    check("ilk_bub1", 32'(sh_valid), 32'd0);
    exmem_wr_en = 1'b0;
    #1;
    check("ilk_clr", 32'(hazard_stall), 32'd0);
    push(16'h0F0F, 4'd2, 2'b01, 3'd1);
    tick();
    pop_cmp("ilk");
    idle_tick();
    // Immediate count ignores an rt match on MEM/WB
    drive(1'b1, 1'b0, 1'b0, 3'd1, 3'd4, 3'd2, 16'h0001, 16'h0000, 1'b1, 4'd3, 2'b00);
    memwb_wr_en = 1'b1; memwb_rd_idx = 3'd4;
    #1;
    check("ilk_imm_mask", 32'(hazard_stall), 32'd0);
    dec_use_imm = 1'b0;
    #1;
    check("ilk_rt_mem", 32'(hazard_stall), 32'd1);
    memwb_wr_en = 1'b0;
    idle_tick();
`endif

    // Load-use hazard on rt
    drive(1'b0, 1'b1, 1'b1, 3'd0, 3'd0, 3'd3, 16'h0000, 16'h0000, 1'b0, 4'd0, 2'b00);
    tick();
    check("ld_notshift", 32'(sh_valid), 32'd0);
    drive(1'b1, 1'b0, 1'b0, 3'd1, 3'd3, 3'd5, 16'h00C3, 16'h0002, 1'b0, 4'd9, 2'b10);
    #1;
    check("lu_haz", 32'(hazard_stall), 32'd1);
    tick();
    check("lu_bubble", 32'(sh_valid), 32'd0);
    check("lu_haz_off", 32'(hazard_stall), 32'd0);
    push(16'h00C3, 4'd2, 2'b10, 3'd5);
    tick();
    pop_cmp("lu");
    idle_tick();

    // Register count wraps to low bits: 0x0013 -> 3
`ifdef SHIFT_FWD_EN
    drive(1'b1, 1'b0, 1'b0, 3'd2, 3'd4, 3'd0, 16'h8001, 16'hFFFF, 1'b0, 4'd0, 2'b01);
    exmem_wr_en = 1'b1; exmem_rd_idx = 3'd4; exmem_data = 16'h0013;
`else
    drive(1'b1, 1'b0, 1'b0, 3'd2, 3'd4, 3'd0, 16'h8001, 16'h0013, 1'b0, 4'd0, 2'b01);
`endif
    push(16'h8001, 4'd3, 2'b01, 3'd0);
    tick();
    pop_cmp("cnt_wrap");
    exmem_wr_en = 1'b0;
    idle_tick();

    // Stall holds for 3 cycles, then flush during stall makes a bubble
    drive(1'b1, 1'b0, 1'b0, 3'd6, 3'd0, 3'd4, 16'h1234, 16'h0000, 1'b1, 4'd7, 2'b10);
    push(16'h1234, 4'd7, 2'b10, 3'd4);
    tick();
    pop_cmp("pre_stall");
    stall_in = 1'b1;
    exmem_wr_en = 1'b1; exmem_rd_idx = 3'd2;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 1'b1, 3'd2, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
            16'($urandom), 16'($urandom), 1'b0, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)));
      #1;
      check("stall_haz_mask", 32'(hazard_stall), 32'd0);
      tick();
      check("stall_vld", 32'(sh_valid), 32'd1);
      check("stall_in",  32'(sh_in),    32'h1234);
      check("stall_cnt", 32'(sh_cnt),   32'd7);
      check("stall_op",  32'(sh_op),    32'd2);
      check("stall_rd",  32'(ex_rd_idx), 32'd4);
    end
    exmem_wr_en = 1'b0;
    flush = 1'b1;
    tick();
    check("flush_vld", 32'(sh_valid), 32'd0);
    flush = 1'b0; stall_in = 1'b0;
    idle_tick();

    // Reset wins over a stall in progress
    drive(1'b1, 1'b0, 1'b0, 3'd1, 3'd0, 3'd3, 16'hBEEF, 16'h0000, 1'b1, 4'd5, 2'b11);
    push(16'hBEEF, 4'd5, 2'b11, 3'd3);
    tick();
    pop_cmp("pre_rst");
    stall_in = 1'b1; rst = 1'b1;
    tick();
    check("rst_stall_vld", 32'(sh_valid), 32'd0);
    check("rst_stall_in",  32'(sh_in),    32'd0);
    check("rst_stall_rd",  32'(ex_rd_idx), 32'd0);
    rst = 1'b0; stall_in = 1'b0;
    idle_tick();

    check("sb_drain", 32'(sbq.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
